// File: rtl/rhs_spi_responder.sv
// rhs_spi_responder: clk-domain model of one RHS-style chip acting as an SPI mode-0 responder.
// Decodes 32-bit command words and returns each word's result two words later.
// Ports:
//   clk, rstn             system clock (>= 4x SCLK) and async active-low reset
//   SCLK, CS, MOSI        SPI inputs from the master (asynchronous to clk)
//   MISO                  response bit, MSB first, changes after SCLK falls
//   word_valid            1-clk pulse per accepted 32-bit word
//   word_out              last accepted command word
//   frame_error           1-clk pulse when CS rises with fewer than 32 bits
//   convert_count         sample counter used by CONVERT
module rhs_spi_responder #(
  parameter logic [15:0] STARTING_SEED = 16'h0000,
  parameter int unsigned REG_COUNT     = 32,
  parameter logic [15:0] CHIP_ID       = 16'h0020
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic        frame_error,
  output logic [15:0] convert_count
);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StAbort} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic [5:0]  bit_cnt_q;
  logic [31:0] rx_q, tx_q, pipe0_q, pipe1_q, result;
  logic [15:0] count_q, rd_data;
  logic [15:0] regs_q [REG_COUNT];
  logic        miso_q, word_valid_q;
  logic [31:0] word_out_q;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic        accept, shift_en, active;
  logic [7:0]  addr;
  logic        addr_in_range;

  // Stages [1:0] synchronize; stage [2] is the previous synchronized value for edge detection.
  // CS resets to 0 so a word already in flight at reset release produces no CS fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      cs_q   <= {cs_q[1:0], CS};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; CS rise has priority over a coincident SCLK rise.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: begin
        if (cs_rise)                                state_d = StAbort;
        else if (sclk_rise && bit_cnt_q == 6'd31)   state_d = StDone;
      end
      StDone:  if (cs_rise) state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    accept      = (state_q == StDone) && cs_rise;
    shift_en    = (state_q == StShift) && sclk_rise && !cs_rise;
    active      = (state_q == StShift) || (state_q == StDone);
    frame_error = (state_q == StAbort);
  end

  // Command decode
  assign addr          = rx_q[23:16];
  assign addr_in_range = 32'(addr) < REG_COUNT;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (32'(addr) == i) rd_data = regs_q[i];
    end
  end

  always_comb begin
    result = '0;
    unique case (rx_q[31:30])
      2'b00: result = {10'h0, rx_q[21:16], count_q};
      2'b01: result = '0;
      2'b10: result = {16'hFFFF, rx_q[15:0]};
      2'b11: begin
        if (addr_in_range)      result = {16'h0, rd_data};
        else if (addr == 8'hFF) result = {16'h0, CHIP_ID};
        else                    result = '0;
      end
      default: result = '0;
    endcase
  end

  // Shift datapath. bit_cnt only advances in StShift, so it saturates at 32 in StDone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
    end else begin
      if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 6'd1;
        rx_q      <= {rx_q[30:0], mosi_s};
      end
      if (state_q == StIdle) begin
        if (cs_fall) begin
          bit_cnt_q <= '0;
          tx_q      <= pipe1_q;
          miso_q    <= pipe1_q[31];
        end else begin
          miso_q    <= 1'b0;
        end
      end else if (active && sclk_fall) begin
        tx_q   <= tx_q << 1;
        miso_q <= (bit_cnt_q < 6'd32) ? tx_q[30] : 1'b0;
      end
    end
  end

  // Accept: two-deep response pipeline and counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      pipe0_q      <= '0;
      pipe1_q      <= '0;
      count_q      <= STARTING_SEED;
    end else begin
      word_valid_q <= accept;
      if (accept) begin
        word_out_q <= rx_q;
        pipe1_q    <= pipe0_q;
        pipe0_q    <= result;
        if (rx_q[31:30] == 2'b00) count_q <= count_q + 16'd1;
      end
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (accept && rx_q[31:30] == 2'b10) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (32'(addr) == i) regs_q[i] <= rx_q[15:0];
      end
    end
  end

  assign MISO          = miso_q;
  assign word_valid    = word_valid_q;
  assign word_out      = word_out_q;
  assign convert_count = count_q;

endmodule
